// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD register-port controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_e;

  // Store-word field positions
  localparam int unsigned LCD_ON_BIT     = 31;
  localparam int unsigned LCD_OVFCLR_BIT = 30;
  localparam int unsigned LCD_RS_BIT     = 9;

  // Commands that need the long execute wait
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Status word field positions
  localparam int unsigned STAT_BUSY_BIT = 31;
  localparam int unsigned STAT_FULL_BIT = 30;
  localparam int unsigned STAT_OVF_BIT  = 29;
  localparam int unsigned STAT_CNT_W    = 5;
  localparam int unsigned STAT_PAD_W    = 24;

  localparam int unsigned LCD_CMD_W = 9;

  // Queued command payload
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear and home run much longer inside the panel controller
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_ctrl_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read and push-on-full-with-pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_c, do_pop_c;

  assign o_full    = (count_q == CW'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign o_rdata   = mem_q[rd_ptr_q];
  assign do_pop_c  = i_pop && !o_empty;
  assign do_push_c = i_push && (!o_full || do_pop_c);

  // Storage array, written only on an accepted push
  always_ff @(posedge i_clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= i_wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push_c && !do_pop_c)      count_q <= count_q + CW'(1);
      else if (!do_push_c && do_pop_c) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD register-port responder: queues stored commands and sequences the panel pins.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_status,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_EN), max_u(T_HOLD, T_EXEC)), T_CLR);
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             on_q, on_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      status_q, status_d;

  logic             pop_c, push_c;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    cnt_nxt_c;
  logic [LCD_CMD_W-1:0] fifo_rdata;
  lcd_cmd_t         head_c, wcmd_c;
  logic             unused_c;

  assign head_c   = lcd_cmd_t'(fifo_rdata);
  assign wcmd_c   = '{rs: i_wdata[LCD_RS_BIT], data: i_wdata[7:0]};
  assign unused_c = ^{i_wdata[29:10], i_wdata[8]};

  sync_fifo #(
    .WIDTH (LCD_CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_c),
    .i_wdata (wcmd_c),
    .i_pop   (pop_c),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Phase sequencer: each phase lasts exactly its programmed cycle count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          rs_d    = head_c.rs;
          data_d  = head_c.data;
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(T_EN - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_EXEC;
          cnt_d   = is_long_cmd(rs_q, data_q) ? CNT_W'(T_CLR - 1) : CNT_W'(T_EXEC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    en_d = (state_d == ST_PULSE);
  end

  // Register-port write side: power bit, overflow flag and queue acceptance
  always_comb begin
    on_d   = on_q;
    ovf_d  = ovf_q;
    push_c = 1'b0;
    if (i_wr) begin
      on_d = i_wdata[LCD_ON_BIT];
      if (i_wdata[LCD_OVFCLR_BIT]) begin
        ovf_d = 1'b0;
      end else if (!fifo_full || pop_c) begin
        push_c = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Next status word, so the load path sees the same cycle's state as the pins
  always_comb begin
    cnt_nxt_c = fifo_count;
    if (push_c && !pop_c)      cnt_nxt_c = fifo_count + CW'(1);
    else if (!push_c && pop_c) cnt_nxt_c = fifo_count - CW'(1);
    status_d = {(cnt_nxt_c != '0) || (state_d != ST_IDLE),
                (cnt_nxt_c == CW'(DEPTH)),
                ovf_d,
                {STAT_PAD_W{1'b0}},
                STAT_CNT_W'(cnt_nxt_c)};
  end

  // State, counter and pin registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      data_q   <= '0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      ovf_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      en_q     <= en_d;
      on_q     <= on_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
    end
  end

  assign o_status   = status_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized bench for lcd_ctrl against a timeline model of the command stream.
module tb_lcd_ctrl;

  localparam int DEPTH   = 4;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 3;
  localparam int T_HOLD  = 1;
  localparam int T_EXEC  = 5;
  localparam int T_CLR   = 20;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_status;
  logic        o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [7:0]  o_lcd_data;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .DEPTH   (DEPTH),
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_HOLD  (T_HOLD),
    .T_EXEC  (T_EXEC),
    .T_CLR   (T_CLR)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_wr       (i_wr),
    .i_wdata    (i_wdata),
    .o_status   (o_status),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_data (o_lcd_data)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: queue of accepted commands plus the time window of the active command
  logic [8:0] q_m[$];
  logic       ovf_m = 1'b0, on_m = 1'b0, rs_m = 1'b0;
  logic [7:0] data_m = '0;
  int         en_rise = -1, en_fall = -1, idle_from = 0;
  logic       prev_en = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance the model by one clock edge given the inputs presented during the cycle
  task automatic model_step(input logic rst, input logic wr, input logic [31:0] wd);
    logic [8:0] cmd;
    int         ex;
    if (rst) begin
      q_m.delete();
      ovf_m = 1'b0; on_m = 1'b0; rs_m = 1'b0; data_m = '0;
      en_rise = -1; en_fall = -1; idle_from = cyc;
      return;
    end
    if ((cyc - 1 >= idle_from) && (q_m.size() != 0)) begin
      cmd     = q_m.pop_front();
      rs_m    = cmd[8];
      data_m  = cmd[7:0];
      en_rise = cyc + T_SETUP;
      en_fall = en_rise + T_EN;
      ex      = (!rs_m && (data_m == 8'h01 || data_m == 8'h02)) ? T_CLR : T_EXEC;
      idle_from = en_fall + T_HOLD + ex;
    end
    if (wr) begin
      on_m = wd[31];
      if (wd[30])                  ovf_m = 1'b0;
      else if (q_m.size() < DEPTH) q_m.push_back({wd[9], wd[7:0]});
      else                         ovf_m = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic busy;
    busy = (q_m.size() != 0) || (cyc < idle_from);
    return {busy, q_m.size() == DEPTH, ovf_m, 24'b0, 5'(q_m.size())};
  endfunction

  task automatic compare_all();
    logic exp_en;
    exp_en = (cyc >= en_rise) && (cyc < en_fall);
    check("status", o_status, exp_status());
    check("en", 32'(o_lcd_en), 32'(exp_en));
    check("rs", 32'(o_lcd_rs), 32'(rs_m));
    check("data", 32'(o_lcd_data), 32'(data_m));
    check("on", 32'(o_lcd_on), 32'(on_m));
    check("rw", 32'(o_lcd_rw), 32'd0);
    if (prev_en && o_lcd_en) begin
      check("rs_stable_en", 32'(o_lcd_rs), 32'(prev_rs));
      check("data_stable_en", 32'(o_lcd_data), 32'(prev_data));
    end
    prev_en = o_lcd_en; prev_rs = o_lcd_rs; prev_data = o_lcd_data;
  endtask

  task automatic tick(input logic rst, input logic wr, input logic [31:0] wd);
    i_reset = rst; i_wr = wr; i_wdata = wd;
    @(posedge clk);
    cyc++;
    model_step(rst, wr, wd);
    #1;
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && ((q_m.size() != 0) || (cyc < idle_from)); i++) tick(1'b0, 1'b0, '0);
    check("drain_busy", 32'(o_status[31]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, en_first, busy0, pv;
    logic [31:0] wd;
    logic        found;

    // Reset
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    check("rst_status", o_status, 32'd0);
    check("rst_pins", {o_lcd_on, o_lcd_rs, o_lcd_en, o_lcd_data}, 32'd0);

    // 1: single data write, absolute timing
    t0 = cyc; en_first = -1; busy0 = -1;
    tick(1'b0, 1'b1, 32'h8000_0241);
    check("t1_on", 32'(o_lcd_on), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, '0);
      if (cyc - t0 == 2) begin
        check("t1_rs", 32'(o_lcd_rs), 32'd1);
        check("t1_data", 32'(o_lcd_data), 32'h41);
      end
      if (o_lcd_en && en_first < 0) en_first = cyc - t0;
      if (!o_status[31] && busy0 < 0) busy0 = cyc - t0;
    end
    check("t1_en_rise", 32'(en_first), 32'd4);
    check("t1_idle", 32'(busy0), 32'd13);

    // 2: clear command uses the long execute time
    pv = -1; busy0 = -1;
    tick(1'b0, 1'b1, 32'h0000_0001);
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0, '0);
      if (pv < 0 && !o_lcd_rs && o_lcd_data == 8'h01) pv = cyc;
      else if (pv >= 0 && busy0 < 0 && !o_status[31]) busy0 = cyc;
    end
    check("t2_clr_len", 32'(busy0 - pv), 32'd26);

    // 3: overflow on the sixth back-to-back write, then clear it
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 32'h8000_0230 + 32'(i));
    check("t3_full", 32'(o_status[30]), 32'd1);
    check("t3_ovf", 32'(o_status[29]), 32'd1);
    check("t3_count", 32'(o_status[4:0]), 32'd4);
    tick(1'b0, 1'b1, 32'h4000_0000);
    check("t3_ovf_clr", 32'(o_status[29]), 32'd0);
    check("t3_count_kept", 32'(o_status[4:0]), 32'd4);

    // 4: write into a full queue on the cycle the sequencer pops
    for (int i = 0; i < 200 && !((cyc >= idle_from) && (q_m.size() != 0)); i++) tick(1'b0, 1'b0, '0);
    check("t4_reached_pop", 32'(q_m.size()), 32'(DEPTH));
    tick(1'b0, 1'b1, 32'h8000_0033);
    check("t4_ovf", 32'(o_status[29]), 32'd0);
    check("t4_count", 32'(o_status[4:0]), 32'd4);
    drain();

    // 5: reset while EN is high
    tick(1'b0, 1'b1, 32'h8000_0255);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 1'b0, '0);
      found = o_lcd_en;
    end
    check("t5_en_wait", 32'(found), 32'd1);
    tick(1'b1, 1'b0, '0);
    check("t5_en", 32'(o_lcd_en), 32'd0);
    check("t5_data", 32'(o_lcd_data), 32'd0);
    check("t5_on", 32'(o_lcd_on), 32'd0);
    check("t5_status", o_status, 32'd0);
    tick(1'b0, 1'b1, 32'h8000_0248);
    drain();

    // 6: random command stream
    for (int i = 0; i < 1500; i++) begin
      wd = $urandom;
      wd[30] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        wd[9]   = 1'b0;
        wd[7:0] = 8'($urandom_range(1, 2));
      end
      tick(1'b0, ($urandom_range(0, 3) == 0), wd);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
